// File: rtl/counter_arbiter.sv
`timescale 1ns/1ps
// Round-robin owner of one shared loadable up-counter: grants a requester, loads its start
// value, waits for terminal count, then pulses done. Optional watchdog: CNT_ARB_WDOG_EN.
module counter_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ*WIDTH-1:0]     req_data_i,
    output logic [NREQ-1:0]           gnt_o,
    output logic [NREQ-1:0]           done_o,
    output logic                      busy_o,
    output logic [$clog2(NREQ)-1:0]   cur_id_o,
    output logic                      cnt_load_o,
    output logic [WIDTH-1:0]          cnt_data_o,
    input  logic [WIDTH-1:0]          cnt_count_i
`ifdef CNT_ARB_WDOG_EN
    ,
    output logic                      err_o
`endif
);

    localparam int unsigned IdW = $clog2(NREQ);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   last_q, last_d;
    logic [IdW-1:0]   cur_id_q, cur_id_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IdW-1:0]   sel;
    logic [IdW-1:0]   idx;
    logic             found;

`ifdef CNT_ARB_WDOG_EN
    logic [WIDTH:0]   wdog_q, wdog_d;
`endif

    // First pending requester strictly after the previous owner, wrapping modulo NREQ.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IdW'((32'(last_q) + k) % NREQ);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cur_id_d   = cur_id_q;
        data_d     = data_q;
        gnt_o      = '0;
        done_o     = '0;
        cnt_load_o = 1'b0;
`ifdef CNT_ARB_WDOG_EN
        wdog_d     = wdog_q;
        err_o      = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_o    = NREQ'(1) << sel;
                    data_d   = req_data_i[sel*WIDTH +: WIDTH];
                    cur_id_d = sel;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                cnt_load_o = 1'b1;
                state_d    = StRun;
`ifdef CNT_ARB_WDOG_EN
                wdog_d     = '0;
`endif
            end
            StRun: begin
                if (cnt_count_i == '1) begin
                    state_d = StDone;
                end
`ifdef CNT_ARB_WDOG_EN
                // 2^WIDTH+1 RUN cycles can never happen with a healthy counter.
                else if (wdog_q == {1'b1, {WIDTH{1'b0}}}) begin
                    err_o   = 1'b1;
                    last_d  = cur_id_q;
                    state_d = StIdle;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            StDone: begin
                done_o  = NREQ'(1) << cur_id_q;
                last_d  = cur_id_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            last_q   <= IdW'(NREQ - 1);
            cur_id_q <= '0;
            data_q   <= '0;
`ifdef CNT_ARB_WDOG_EN
            wdog_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cur_id_q <= cur_id_d;
            data_q   <= data_d;
`ifdef CNT_ARB_WDOG_EN
            wdog_q   <= wdog_d;
`endif
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign cur_id_o   = busy_o ? cur_id_q : '0;
    assign cnt_data_o = data_q;

endmodule
